fetch: RTL and testbench
========================

Name: fetch

Overview:
- Instruction fetch stage directly upstream of the control decoder.
- Holds the PC and issues word reads to instruction memory over a req/gnt + rvalid handshake, one read outstanding at a time.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts a redirect (jump/branch-taken) from decode, which flushes buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset; bits [1:0] must be 0.
- DEPTH, 2, instruction FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- imem_req  output  1  read request valid.
- imem_addr  output  32  read word address (byte address, [1:0]=0).
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  read data.
- instr_valid  output  1  instr/instr_pc hold a valid instruction.
- instr_ready  input  1  decode consumes the head this cycle.
- instr  output  32  instruction word; decode slices opcode [31:26], funct [5:0].
- instr_pc  output  32  address of instr.
- jump  input  1  redirect pulse from control, qualified by decode.
- jump_addr  input  32  redirect target; bits [1:0] ignored, treated as 0.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, FIFO empty, state=IDLE.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0.
- State machine, states IDLE, WAIT, DROP:
  - IDLE: imem_req=1 iff free_slots>0 and jump=0; imem_addr=pc.
    - On imem_req&imem_gnt: req_pc<=pc, pc<=pc+4 (mod 2^32), go WAIT.
  - WAIT: imem_req=0. On imem_rvalid: push {req_pc, imem_rdata}, go IDLE.
  - DROP: imem_req=0. On imem_rvalid: discard data, go IDLE.
  - imem_rvalid in IDLE is ignored (covers stale responses after reset).
- Redirect (jump=1) has highest priority:
  - FIFO flushed, pc<=jump_addr with [1:0] cleared.
  - From WAIT: go DROP. An rvalid in the same cycle as jump is also discarded, so go IDLE instead.
  - From DROP: stay DROP. If rvalid arrives the same cycle, go IDLE.
  - From IDLE: no request is issued that cycle; stay IDLE.
  - An instr_ready in the same cycle as jump is a normal consume of the head (already counted by decode); the flush removes the remaining entries.
- FIFO:
  - free_slots = DEPTH − count − (state==WAIT ? 1 : 0).
  - This guarantees every granted read has a slot, so no overflow is possible.
  - Push and pop in the same cycle keep count unchanged.
  - instr_valid = count≠0. instr/instr_pc come from the head entry, registered (no combinational path from imem_rdata).
  - instr, instr_pc hold their value while instr_valid=1 and instr_ready=0.
- Latency and throughput:
  - grant at cycle N, rvalid at N+k → instr_valid at N+k+1.
  - Next request no earlier than N+k+1.
  - Peak throughput is 1 instr per 2 cycles at k=1.
- pc wraps 32'hFFFF_FFFC → 32'h0000_0000 silently.
- Reset asserted mid-operation clears all state immediately. A pending memory response after release is ignored, as it arrives in IDLE.
- Sim-only check, disabled for synthesis: display an error if imem_rvalid arrives in IDLE after the first request, or if a push would overflow the FIFO.

Test Plan:
- Reset release with RESET_PC=0, imem_gnt=1, 1-cycle memory returning addr+32'h1000, instr_ready=1:
  - imem_addr sequence is 0,4,8,…
  - instr_pc/instr pairs (0,32'h1000),(4,32'h1004), one every 2 cycles.
- Backpressure, instr_ready=0 for 10 cycles:
  - exactly DEPTH=2 instructions fetched, then imem_req stays 0.
  - instr holds head (pc 0).
  - after release, order 0,4,8 with no loss or duplicate.
- jump=1, jump_addr=32'h0000_0103 while in WAIT for pc 8:
  - response for 8 discarded, FIFO flushed.
  - next imem_addr=32'h0000_0100, next instr_pc=32'h100.
- jump asserted in the same cycle as imem_rvalid:
  - that data is never presented.
  - state is IDLE next cycle; imem_addr=jump target.
- imem_gnt held 0 for 5 cycles:
  - imem_req/imem_addr stable at the same pc throughout, pc not advanced.
- RESET_PC=32'hFFFF_FFF8, run 3 fetches:
  - instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset asserted mid-WAIT, then a late rvalid after release:
  - outputs clear immediately, late response ignored.
  - first fetch from RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory read handshake plus the decode-side instruction handshake.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        jump;
  logic [31:0] jump_addr;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, jump, jump_addr
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, jump, jump_addr
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: PC, one-outstanding imem reads, small instruction FIFO toward decode.
// A redirect from decode flushes the FIFO and drops any read still in flight.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.master bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_req_pc;
  entry_t        r_mem [DEPTH];
  entry_t        r_head;
  entry_t        w_push_entry;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_used;
  logic          w_has_free;
  logic          w_req;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic          w_unused;

  // An outstanding read already owns a slot, so a grant can never overflow the FIFO.
  assign w_used       = r_count + CW'(r_state == S_WAIT);
  assign w_has_free   = w_used < CW'(DEPTH);
  assign w_req        = rst_n && (r_state == S_IDLE) && w_has_free && !bus.jump;
  assign w_fire       = w_req && bus.imem_gnt;
  assign w_push       = (r_state == S_WAIT) && bus.imem_rvalid && !bus.jump;
  assign w_valid      = (r_count != '0);
  assign w_pop        = w_valid && bus.instr_ready;
  assign w_push_entry = '{pc: r_req_pc, word: bus.imem_rdata};
  assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
  assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
  assign w_unused     = &{1'b0, bus.jump_addr[1:0]};

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = r_head.word;
  assign bus.instr_pc    = r_head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A response coinciding with a redirect is simply discarded, so WAIT/DROP return to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_fire) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.imem_rvalid)  w_state_nxt = S_IDLE;
        else if (bus.jump)    w_state_nxt = S_DROP;
      end
      S_DROP: if (bus.imem_rvalid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
    end else if (bus.jump) begin
      r_pc <= {bus.jump_addr[31:2], 2'b00};
    end else if (w_fire) begin
      r_pc     <= r_pc + 32'd4;
      r_req_pc <= r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_entry;
  end

  // Head register is preloaded with next cycle's head so decode sees only flop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (bus.jump) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      if (w_count_nxt != '0) begin
        r_head <= (w_push && (r_wr_ptr == w_rd_ptr_nxt)) ? w_push_entry : r_mem[w_rd_ptr_nxt];
      end
    end
  end

`ifndef SYNTHESIS
  logic r_granted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_granted <= 1'b0;
    else if (w_fire) r_granted <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n && r_granted && (r_state == S_IDLE) && bus.imem_rvalid)
      $error("fetch: imem_rvalid with no read outstanding");
    if (rst_n && w_push && !w_pop && (r_count == CW'(DEPTH)))
      $error("fetch: instruction FIFO overflow");
  end
`endif
endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: a small memory model with programmable latency and a recording consumer.
module tb_fetch;
  logic clk = 1'b0;
  logic rst_n;
  logic rst_nb;

  always #5 clk = ~clk;

  fetch_if ifa ();
  fetch_if ifb ();

  fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut_a (.clk(clk), .rst_n(rst_n),  .bus(ifa));
  fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_b (.clk(clk), .rst_n(rst_nb), .bus(ifb));

  int          n_chk;
  int          n_err;
  int          cyc_n;
  int unsigned lat;
  logic        a_busy;
  int unsigned a_cnt;
  logic [31:0] a_addr;
  logic        b_fire;
  logic [31:0] b_addr;
  int          stable;

  logic [31:0] iss_q [$];
  logic [63:0] cons_q [$];
  int          cons_t [$];
  logic [63:0] consb_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] iss_at(input int i);
    if (i < iss_q.size()) return iss_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [63:0] cons_at(input int i);
    if (i < cons_q.size()) return cons_q[i];
    return {64{1'b1}};
  endfunction

  function automatic logic [63:0] consb_at(input int i);
    if (i < consb_q.size()) return consb_q[i];
    return {64{1'b1}};
  endfunction

  function automatic int t_at(input int i);
    if (i < cons_t.size()) return cons_t[i];
    return -100;
  endfunction

  // Record handshakes just before the edge, then drive memory responses just after it.
  task automatic tick();
    #1;
    if (ifa.imem_req && ifa.imem_gnt) begin
      iss_q.push_back(ifa.imem_addr);
      a_addr = ifa.imem_addr;
      a_cnt  = lat;
      a_busy = 1'b1;
    end
    if (ifa.instr_valid && ifa.instr_ready) begin
      cons_q.push_back({ifa.instr_pc, ifa.instr});
      cons_t.push_back(cyc_n);
    end
    b_fire = ifb.imem_req && ifb.imem_gnt;
    b_addr = ifb.imem_addr;
    if (ifb.instr_valid && ifb.instr_ready) consb_q.push_back({ifb.instr_pc, ifb.instr});
    @(posedge clk);
    cyc_n++;
    #1;
    ifa.imem_rvalid = 1'b0;
    if (a_busy) begin
      if (a_cnt <= 1) begin
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata  = a_addr + 32'h0000_1000;
        a_busy          = 1'b0;
      end else begin
        a_cnt--;
      end
    end
    ifb.imem_rvalid = b_fire;
    ifb.imem_rdata  = b_addr + 32'h0000_1000;
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    ifa.imem_gnt    = 1'b0;
    ifa.instr_ready = 1'b0;
    ifa.jump        = 1'b0;
    ifa.jump_addr   = 32'h0;
    ifa.imem_rvalid = 1'b0;
    ifa.imem_rdata  = 32'h0;
    a_busy          = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    iss_q.delete();
    cons_q.delete();
    cons_t.delete();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;
    n_chk = 0; n_err = 0; cyc_n = 0; lat = 1;
    a_busy = 1'b0; a_cnt = 0; a_addr = 32'h0; b_fire = 1'b0; b_addr = 32'h0;
    rst_n = 1'b1; rst_nb = 1'b1;
    ifa.imem_gnt = 1'b0; ifa.imem_rvalid = 1'b0; ifa.imem_rdata = 32'h0;
    ifa.instr_ready = 1'b0; ifa.jump = 1'b0; ifa.jump_addr = 32'h0;
    ifb.imem_gnt = 1'b1; ifb.imem_rvalid = 1'b0; ifb.imem_rdata = 32'h0;
    ifb.instr_ready = 1'b1; ifb.jump = 1'b0; ifb.jump_addr = 32'h0;
    #1;
    rst_n = 1'b0; rst_nb = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_req",    32'(ifa.imem_req),    32'd0);
    check("rst_addr",   ifa.imem_addr,        32'h0000_0000);
    check("rst_valid",  32'(ifa.instr_valid), 32'd0);
    check("rst_instr",  ifa.instr,            32'h0);
    check("rst_ipc",    ifa.instr_pc,         32'h0);
    check("rst_addr_b", ifb.imem_addr,        32'hFFFF_FFF8);

    // Streaming at 1-cycle memory latency
    do_reset();
    ifa.imem_gnt = 1'b1; ifa.instr_ready = 1'b1; lat = 1;
    repeat (7) tick();
    check("s_addr0", iss_at(0), 32'h0);
    check("s_addr1", iss_at(1), 32'h4);
    check("s_addr2", iss_at(2), 32'h8);
    e = cons_at(0); check("s_pc0", e[63:32], 32'h0); check("s_in0", e[31:0], 32'h1000);
    e = cons_at(1); check("s_pc1", e[63:32], 32'h4); check("s_in1", e[31:0], 32'h1004);
    e = cons_at(2); check("s_pc2", e[63:32], 32'h8); check("s_in2", e[31:0], 32'h1008);
    check("s_gap01", 32'(t_at(1) - t_at(0)), 32'd2);
    check("s_gap12", 32'(t_at(2) - t_at(1)), 32'd2);

    // Backpressure: FIFO fills, fetching stops, head holds
    do_reset();
    ifa.imem_gnt = 1'b1; ifa.instr_ready = 1'b0; lat = 1;
    repeat (10) tick();
    check("bp_nfetch", 32'(iss_q.size()),     32'd2);
    check("bp_req",    32'(ifa.imem_req),     32'd0);
    check("bp_valid",  32'(ifa.instr_valid),  32'd1);
    check("bp_ipc",    ifa.instr_pc,          32'h0);
    check("bp_instr",  ifa.instr,             32'h1000);
    ifa.instr_ready = 1'b1;
    repeat (6) tick();
    check("bp_ncons", 32'(cons_q.size()), 32'd4);
    e = cons_at(0); check("bp_pc0", e[63:32], 32'h0);
    e = cons_at(1); check("bp_pc1", e[63:32], 32'h4);
    e = cons_at(2); check("bp_pc2", e[63:32], 32'h8); check("bp_in2", e[31:0], 32'h1008);

    // Redirect while waiting on pc 8 with pc 4 still buffered
    do_reset();
    ifa.imem_gnt = 1'b1; ifa.instr_ready = 1'b1; lat = 3;
    for (int i = 0; i < 40 && cons_q.size() < 1; i++) tick();
    ifa.instr_ready = 1'b0;
    for (int i = 0; i < 40 && iss_q.size() < 3; i++) tick();
    check("jw_pre_pc", ifa.instr_pc, 32'h4);
    ifa.jump = 1'b1; ifa.jump_addr = 32'h0000_0103;
    tick();
    ifa.jump = 1'b0;
    #1;
    check("jw_valid", 32'(ifa.instr_valid), 32'd0);
    check("jw_req",   32'(ifa.imem_req),    32'd0);
    check("jw_pc",    ifa.imem_addr,        32'h0000_0100);
    ifa.instr_ready = 1'b1;
    for (int i = 0; i < 40 && cons_q.size() < 2; i++) tick();
    check("jw_addr3", iss_at(3), 32'h0000_0100);
    e = cons_at(1); check("jw_ipc", e[63:32], 32'h100); check("jw_in", e[31:0], 32'h1100);

    // Redirect in the same cycle as the response
    do_reset();
    ifa.imem_gnt = 1'b1; ifa.instr_ready = 1'b1; lat = 1;
    tick();
    ifa.jump = 1'b1; ifa.jump_addr = 32'h0000_0200;
    tick();
    ifa.jump = 1'b0;
    #1;
    check("js_req",   32'(ifa.imem_req),    32'd1);
    check("js_addr",  ifa.imem_addr,        32'h0000_0200);
    check("js_valid", 32'(ifa.instr_valid), 32'd0);
    for (int i = 0; i < 40 && cons_q.size() < 1; i++) tick();
    e = cons_at(0); check("js_ipc", e[63:32], 32'h200); check("js_in", e[31:0], 32'h1200);

    // Grant withheld: request and address stay put
    do_reset();
    ifa.imem_gnt = 1'b0; ifa.instr_ready = 1'b1; lat = 1;
    stable = 0;
    repeat (5) begin
      if (ifa.imem_req && (ifa.imem_addr == 32'h0)) stable++;
      tick();
    end
    check("ng_stable", 32'(stable), 32'd5);
    ifa.imem_gnt = 1'b1;
    tick();
    check("ng_addr0", iss_at(0),     32'h0);
    check("ng_pcadv", ifa.imem_addr, 32'h4);

    // PC wrap on the second instance
    rst_nb = 1'b1;
    consb_q.delete();
    repeat (8) tick();
    e = consb_at(0); check("wr_pc0", e[63:32], 32'hFFFF_FFF8); check("wr_in0", e[31:0], 32'h0000_0FF8);
    e = consb_at(1); check("wr_pc1", e[63:32], 32'hFFFF_FFFC); check("wr_in1", e[31:0], 32'h0000_0FFC);
    e = consb_at(2); check("wr_pc2", e[63:32], 32'h0000_0000); check("wr_in2", e[31:0], 32'h0000_1000);

    // Async reset mid-WAIT, response arrives after release
    do_reset();
    ifa.imem_gnt = 1'b1; ifa.instr_ready = 1'b0; lat = 3;
    for (int i = 0; i < 40 && iss_q.size() < 2; i++) tick();
    check("ar_pre_valid", 32'(ifa.instr_valid), 32'd1);
    rst_n = 1'b0;
    ifa.imem_gnt = 1'b0;
    #1;
    check("ar_valid", 32'(ifa.instr_valid), 32'd0);
    check("ar_instr", ifa.instr,            32'h0);
    check("ar_ipc",   ifa.instr_pc,         32'h0);
    check("ar_addr",  ifa.imem_addr,        32'h0);
    check("ar_req",   32'(ifa.imem_req),    32'd0);
    iss_q.delete(); cons_q.delete(); cons_t.delete();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("ar_late", 32'(ifa.instr_valid), 32'd0);
    ifa.imem_gnt = 1'b1; ifa.instr_ready = 1'b1;
    for (int i = 0; i < 40 && cons_q.size() < 1; i++) tick();
    check("ar_addr0", iss_at(0), 32'h0);
    e = cons_at(0); check("ar_ipc0", e[63:32], 32'h0); check("ar_in0", e[31:0], 32'h1000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
